// File: rtl/cfg_pkg.sv
// Shared configuration for the I2C transaction arbiter:
// arbiter state encoding and default widths/timeouts.
package cfg_pkg;

    localparam int DATA_WIDTH           = 8;
    localparam int HOLD_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BUSY,
        ST_RESP,
        ST_FSTOP,
        ST_FWAIT
    } arb_state_e;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] winner_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o    = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                winner_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-level I2C master command port between N_REQ requesters,
// granting whole transactions round-robin and forcing STOP on abandon/stall.
module i2c_txn_arbiter
    import cfg_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int DATA_WIDTH   = cfg_pkg::DATA_WIDTH,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic [N_REQ-1:0]            req_i,
    output logic [N_REQ-1:0]            gnt_o,
    input  logic [N_REQ-1:0]            req_start_i,
    input  logic [N_REQ-1:0]            req_stop_i,
    input  logic [N_REQ-1:0]            req_read_i,
    input  logic [N_REQ-1:0]            req_write_i,
    input  logic [N_REQ-1:0]            req_ack_in_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_din_i,
    output logic [N_REQ-1:0]            req_cmd_ack_o,
    output logic [DATA_WIDTH-1:0]       req_dout_o,
    output logic                        m_start_o,
    output logic                        m_stop_o,
    output logic                        m_read_o,
    output logic                        m_write_o,
    output logic                        m_ack_in_o,
    output logic [DATA_WIDTH-1:0]       m_din_o,
    input  logic [DATA_WIDTH-1:0]       m_dout_i,
    input  logic                        m_cmd_ack_i,
    output logic                        err_o,
    output logic                        force_stop_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);

    arb_state_e            state_q;
    logic [N_REQ-1:0]      gnt_q;
    logic [IW-1:0]         g_q;
    logic [IW-1:0]         ptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  last_stop_q;
    logic [N_REQ-1:0]      cmd_ack_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  m_start_q, m_stop_q, m_read_q, m_write_q, m_ack_in_q;
    logic [DATA_WIDTH-1:0] m_din_q;
    logic                  err_q;
    logic                  fstop_q;

    logic [N_REQ-1:0]      rr_gnt;
    logic [IW-1:0]         rr_win;
    logic [IW-1:0]         ptr_d;
    logic                  cmd_any;
    logic                  cmd_bad;
    logic [DATA_WIDTH-1:0] cmd_din;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .gnt_o    (rr_gnt),
        .winner_o (rr_win)
    );

    assign ptr_d   = (rr_win == IW'(N_REQ - 1)) ? '0 : rr_win + 1'b1;
    assign cmd_any = req_start_i[g_q] | req_stop_i[g_q] | req_read_i[g_q]
                   | req_write_i[g_q] | req_ack_in_i[g_q];
    assign cmd_bad = req_read_i[g_q] & req_write_i[g_q];
    assign cmd_din = req_din_i[g_q*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            g_q         <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            last_stop_q <= 1'b0;
            cmd_ack_q   <= '0;
            dout_q      <= '0;
            m_start_q   <= 1'b0;
            m_stop_q    <= 1'b0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_ack_in_q  <= 1'b0;
            m_din_q     <= '0;
            err_q       <= 1'b0;
            fstop_q     <= 1'b0;
        end else begin
            cmd_ack_q <= '0;
            err_q     <= 1'b0;
            fstop_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        gnt_q   <= rr_gnt;
                        g_q     <= rr_win;
                        ptr_q   <= ptr_d;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Dropping req_i wins over any command bits seen the same cycle.
                    if (!req_i[g_q]) begin
                        state_q <= ST_FSTOP;
                    end else if (cmd_any && !cmd_bad) begin
                        m_start_q   <= req_start_i[g_q];
                        m_stop_q    <= req_stop_i[g_q];
                        m_read_q    <= req_read_i[g_q];
                        m_write_q   <= req_write_i[g_q];
                        m_ack_in_q  <= req_ack_in_i[g_q];
                        m_din_q     <= cmd_din;
                        last_stop_q <= req_stop_i[g_q];
                        cnt_q       <= '0;
                        state_q     <= ST_BUSY;
                    end else begin
                        err_q <= cmd_bad;
                        if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
                            state_q <= ST_FSTOP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (m_cmd_ack_i) begin
                        m_start_q  <= 1'b0;
                        m_stop_q   <= 1'b0;
                        m_read_q   <= 1'b0;
                        m_write_q  <= 1'b0;
                        m_ack_in_q <= 1'b0;
                        m_din_q    <= '0;
                        dout_q     <= m_dout_i;
                        cmd_ack_q  <= gnt_q;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cnt_q <= '0;
                    if (last_stop_q) begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_FSTOP: begin
                    gnt_q    <= '0;
                    m_stop_q <= 1'b1;
                    state_q  <= ST_FWAIT;
                end
                ST_FWAIT: begin
                    if (m_cmd_ack_i) begin
                        m_stop_q <= 1'b0;
                        fstop_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o         = gnt_q;
    assign req_cmd_ack_o = cmd_ack_q;
    assign req_dout_o    = dout_q;
    assign m_start_o     = m_start_q;
    assign m_stop_o      = m_stop_q;
    assign m_read_o      = m_read_q;
    assign m_write_o     = m_write_q;
    assign m_ack_in_o    = m_ack_in_q;
    assign m_din_o       = m_din_q;
    assign err_o         = err_q;
    assign force_stop_o  = fstop_q;

endmodule
